// File: rtl/regfile_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
// Shared sizing for the register-file writeback controller.
// The default widths track the core-wide RegBus / RegAddrBus / RegNum values
// (32-bit registers, 5-bit index, 32 architectural registers).
// ---------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

    localparam int RF_DATA_W     = 32;  // RegBus
    localparam int RF_ADDR_W     = 5;   // RegAddrBus
    localparam int RF_REG_NUM    = 32;  // RegNum
    localparam int RF_FIFO_DEPTH = 2;

    // Architectural x0: writes to it are dropped, it is never busy.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous first-word-fall-through FIFO holding {rd, data} for long
// results that lost write-port arbitration.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i  enqueue request and payload (ignored when full)
//   pop_i          dequeue request (ignored when empty)
//   head_o         current head entry, valid while empty_o=0
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: stale entries are unreachable once
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Writer-side controller for the integer register file. Merges ALU results
// (never stalled) and long-latency results onto the single write port, and
// keeps a per-register scoreboard of in-flight long destinations.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid/iss_long/iss_rd issue from decode; long issues set the scoreboard
//   chk_rs1/chk_rs2           decode sources to hazard-check
//   busy_rs1/busy_rs2/busy_rd combinational scoreboard lookups
//   alu_valid/alu_rd/alu_data single-cycle result, highest priority
//   lsu_valid/lsu_rd/lsu_data long-latency result, lsu_ready = FIFO not full
//   we/waddr/wdata            registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int REG_NUM    = RF_REG_NUM,
    parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic              iss_long,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    // ---------------- long-result buffer ----------------
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  ({lsu_rd, lsu_data}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Depends on occupancy only, so upstream sees no combinational path
    // from either valid.
    assign lsu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

    // ---------------- arbitration ----------------
    logic              sel_valid;
    logic              sel_long;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_long  = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        fifo_pop  = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            // Buffered results drain before any new long result so that
            // long writebacks stay in arrival order.
            sel_valid = 1'b1;
            sel_long  = 1'b1;
            fifo_pop  = 1'b1;
            sel_rd    = fifo_head[ENTRY_W-1:DATA_W];
            sel_data  = fifo_head[DATA_W-1:0];
        end else if (lsu_valid) begin
            sel_valid = 1'b1;
            sel_long  = 1'b1;
            sel_rd    = lsu_rd;
            sel_data  = lsu_data;
        end
    end

    // A long result is buffered whenever it is accepted but not bypassed.
    assign fifo_push = lsu_valid && lsu_ready && !fifo_full
                       && (alu_valid || !fifo_empty);

    // ---------------- write port registers ----------------
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        // x0 consumes the slot but never raises the write enable.
        we_d    = sel_valid && (sel_rd != ADDR_W'(ZERO_REG));
        waddr_d = sel_valid ? sel_rd   : waddr_q;
        wdata_d = sel_valid ? sel_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    // ---------------- scoreboard ----------------
    logic [REG_NUM-1:0] sb_q, sb_d;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;
    logic               iss_set;

    assign iss_set = iss_valid && iss_long;

    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_sb
        if (gi == ZERO_REG) begin : g_zero
            // Bit 0 is forced clear every cycle.
            assign set_vec[gi] = 1'b0;
            assign clr_vec[gi] = 1'b1;
        end else begin : g_reg
            assign set_vec[gi] = iss_set  && (iss_rd == ADDR_W'(gi));
            assign clr_vec[gi] = sel_long && (sel_rd == ADDR_W'(gi));
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    assign sb_d = (sb_q & ~clr_vec) | set_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign busy_rs1 = sb_q[chk_rs1];
    assign busy_rs2 = sb_q[chk_rs2];
    assign busy_rd  = sb_q[iss_rd];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Directed stimulus with a write scoreboard: every expected register-file
// write is queued as {addr, data} when its stimulus is driven, and a negedge
// monitor pops and compares each write the DUT produces.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              iss_valid, iss_long;
    logic [ADDR_W-1:0] iss_rd, chk_rs1, chk_rs2;
    logic              busy_rs1, busy_rs2, busy_rd;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    regfile_wb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_long  (iss_long),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: one line per register-file write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [ADDR_W+DATA_W-1:0] e;
            $display("WR  addr=%0d data=0x%08h", waddr, wdata);
            if (exp_q.size() == 0) begin
                check_val("spurious_we", {63'b0, we}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", {59'b0, waddr}, {59'b0, e[ADDR_W+DATA_W-1:DATA_W]});
                check_val("wr_data", {32'b0, wdata}, {32'b0, e[DATA_W-1:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        logic acc;

        // ---- reset with all inputs active ----
        rst = 1'b1;
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
        chk_rs1 = 5'd7; chk_rs2 = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h2222;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_we",        {63'b0, we}, 64'd0);
        check_val("rst_waddr",     {59'b0, waddr}, 64'd0);
        check_val("rst_wdata",     {32'b0, wdata}, 64'd0);
        check_val("rst_lsu_ready", {63'b0, lsu_ready}, 64'd1);
        check_val("rst_busy_rs1",  {63'b0, busy_rs1}, 64'd0);
        check_val("rst_busy_rs2",  {63'b0, busy_rs2}, 64'd0);
        check_val("rst_busy_rd",   {63'b0, busy_rd}, 64'd0);
        rst = 1'b0;
        iss_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        step();

        // ---- ALU only, x0 drop, idle hold ----
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        push_exp(5'd5, 32'h1234);
        step();
        check_val("alu_we",    {63'b0, we}, 64'd1);
        check_val("alu_waddr", {59'b0, waddr}, 64'd5);
        check_val("alu_wdata", {32'b0, wdata}, 64'h1234);
        alu_rd = 5'd0; alu_data = 32'hFFFF;
        step();
        check_val("alu_x0_we", {63'b0, we}, 64'd0);
        alu_rd = 5'd6; alu_data = 32'h66;
        push_exp(5'd6, 32'h66);
        step();
        alu_valid = 1'b0;
        step();
        check_val("idle_we",    {63'b0, we}, 64'd0);
        check_val("idle_waddr", {59'b0, waddr}, 64'd6);
        check_val("idle_wdata", {32'b0, wdata}, 64'h66);

        // ---- long issue and writeback ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
        chk_rs1 = 5'd7; chk_rs2 = 5'd7;
        #1;
        check_val("pre_issue_busy_rd", {63'b0, busy_rd}, 64'd0);
        step();
        iss_valid = 1'b0;
        #1;
        check_val("long_busy_rs1", {63'b0, busy_rs1}, 64'd1);
        check_val("long_busy_rs2", {63'b0, busy_rs2}, 64'd1);
        check_val("long_busy_rd",  {63'b0, busy_rd}, 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0; chk_rs2 = 5'd0;
        #1;
        check_val("x0_never_busy", {63'b0, busy_rs2}, 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEADBEEF;
        push_exp(5'd7, 32'hDEADBEEF);
        step();
        lsu_valid = 1'b0;
        #1;
        check_val("long_we",        {63'b0, we}, 64'd1);
        check_val("long_waddr",     {59'b0, waddr}, 64'd7);
        check_val("long_busy_clr",  {63'b0, busy_rs1}, 64'd0);

        // ---- single collision ----
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        push_exp(5'd3, 32'hA3);
        push_exp(5'd9, 32'h99);
        step();
        check_val("coll_first_waddr", {59'b0, waddr}, 64'd3);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();
        check_val("coll_second_we",    {63'b0, we}, 64'd1);
        check_val("coll_second_waddr", {59'b0, waddr}, 64'd9);

        // ---- three collisions: FIFO fills, order preserved ----
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'h200 + 32'(k);
            push_exp(5'(20 + k), 32'h200 + 32'(k));
            lsu_valid = 1'b1; lsu_rd = 5'(10 + idx); lsu_data = 32'h100 + 32'(idx);
            #1;
            if (k == 2) check_val("burst_full_ready", {63'b0, lsu_ready}, 64'd0);
            acc = lsu_ready;
            step();
            if (acc) idx++;
        end
        alu_valid = 1'b0;
        for (int j = 0; j < 3; j++) push_exp(5'(10 + j), 32'h100 + 32'(j));
        for (int t = 0; t < 10 && idx < 3; t++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + idx); lsu_data = 32'h100 + 32'(idx);
            #1;
            acc = lsu_ready;
            step();
            if (acc) idx++;
        end
        lsu_valid = 1'b0;
        check_val("burst_accepted", 64'(idx), 64'd3);
        repeat (4) step();
        check_val("burst_drained", 64'(exp_q.size()), 64'd0);

        // ---- same-cycle set and clear on rd 4 ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd4; chk_rs1 = 5'd4;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        push_exp(5'd1, 32'h11);
        push_exp(5'd4, 32'h44);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        iss_valid = 1'b0;
        #1;
        check_val("setclr_waddr", {59'b0, waddr}, 64'd4);
        check_val("setclr_busy",  {63'b0, busy_rs1}, 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h45;
        push_exp(5'd4, 32'h45);
        step();
        lsu_valid = 1'b0;
        #1;
        check_val("setclr_second_wdata", {32'b0, wdata}, 64'h45);
        check_val("setclr_final_busy",   {63'b0, busy_rs1}, 64'd0);

        // ---- reset mid-operation ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
        step();
        iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        push_exp(5'd2, 32'h22);
        step();
        alu_rd = 5'd3; alu_data = 32'h33;
        lsu_rd = 5'd9; lsu_data = 32'h99;
        push_exp(5'd3, 32'h33);
        #1;
        check_val("mid_ready_one_entry", {63'b0, lsu_ready}, 64'd1);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check_val("mid_ready_full", {63'b0, lsu_ready}, 64'd0);
        chk_rs1 = 5'd7; chk_rs2 = 5'd9; iss_rd = 5'd7;
        #1;
        check_val("mid_busy_before", {62'b0, busy_rs1, busy_rs2}, 64'd3);
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("mid_we",        {63'b0, we}, 64'd0);
        check_val("mid_lsu_ready", {63'b0, lsu_ready}, 64'd1);
        check_val("mid_busy_rs1",  {63'b0, busy_rs1}, 64'd0);
        check_val("mid_busy_rs2",  {63'b0, busy_rs2}, 64'd0);
        check_val("mid_busy_rd",   {63'b0, busy_rd}, 64'd0);
        for (int t = 0; t < 4; t++) begin
            step();
            check_val("mid_no_write", {63'b0, we}, 64'd0);
        end

        check_val("exp_queue_left", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writer-side controller for the integer register file. It merges single-cycle ALU results and long-latency (load/mul/div) results into the register file's single write port, driving we/waddr/wdata. A per-register scoreboard marks destinations of in-flight long operations so the decode stage can stall on RAW and WAW hazards. A small FIFO buffers long results that lose write-port arbitration.

Parameters:
DATA_W, 32, register width; matches `RegBus
ADDR_W, 5, register index width; matches `RegAddrBus
REG_NUM, 32, number of architectural registers; matches `RegNum
FIFO_DEPTH, 2, long-result buffer entries; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_valid  in  1  decode issues an instruction this cycle
iss_long  in  1  issued instruction is long-latency (sets scoreboard)
iss_rd  in  ADDR_W  destination of the issued instruction
chk_rs1  in  ADDR_W  source 1 of the instruction in decode
chk_rs2  in  ADDR_W  source 2 of the instruction in decode
busy_rs1  out  1  chk_rs1 has a pending long write (combinational)
busy_rs2  out  1  chk_rs2 has a pending long write (combinational)
busy_rd  out  1  iss_rd has a pending long write (WAW check, combinational)
alu_valid  in  1  ALU result valid; never back-pressured
alu_rd  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
lsu_valid  in  1  long-latency result valid
lsu_rd  in  ADDR_W  long-latency destination
lsu_data  in  DATA_W  long-latency result
lsu_ready  out  1  long-latency result accepted; high iff FIFO not full
we  out  1  register file write enable (registered)
waddr  out  ADDR_W  register file write address (registered)
wdata  out  DATA_W  register file write data (registered)

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled at posedge clk.
- Reset: we=0, waddr=0, wdata=0. FIFO is emptied (pointers and count 0). All scoreboard bits are cleared. lsu_ready=1 in the first cycle after reset.
- Reset mid-operation: buffered long results are discarded and not written. The scoreboard clears. The upstream pipeline is flushed by the same rst.
- Latency: any accepted write appears on we/waddr/wdata exactly 1 cycle after selection (registered output).
- Arbitration each cycle, in priority order:
  (1) alu_valid=1: the ALU result is selected. If lsu_valid && lsu_ready, the long result is enqueued.
  (2) No ALU and FIFO non-empty: the FIFO head is popped and selected. If lsu_valid && lsu_ready, the long result is enqueued in the same cycle (simultaneous push/pop keeps the count constant).
  (3) No ALU and FIFO empty: if lsu_valid, the long result bypasses the FIFO and is selected directly.
  (4) Otherwise no write: next we=0; waddr and wdata hold their previous values.
- lsu_ready is a function of the current FIFO count only (count<FIFO_DEPTH). It does not depend on lsu_valid or alu_valid.
- Long-result ordering is strict FIFO; FIFO pointers wrap modulo FIFO_DEPTH.
- Destination x0: a selected write with rd=0 still consumes its arbitration slot but drives next we=0. The register file also ignores x0.
- Scoreboard, one bit per register (REG_NUM bits, bit 0 hardwired 0):
  - Set at posedge when iss_valid && iss_long && iss_rd!=0.
  - Clear at the posedge where a long result for that rd is selected (bypass or pop), i.e. in the same cycle the write is registered.
  - Set and clear of the same register in the same cycle: set wins.
- busy_rs1 = sb[chk_rs1], busy_rs2 = sb[chk_rs2], busy_rd = sb[iss_rd]; all combinational, all 0 for index 0.
- A long result draining to the register file does not need a bypass from this block: the register file forwards wdata when waddr matches the read address. Decode may therefore un-stall in the cycle after the busy bit clears.
- The decode stage must stall while busy_rd=1 before issuing to that rd. A long result arriving for an rd whose scoreboard bit is clear is still written.
- An ALU write to a register whose scoreboard bit is set does not change the scoreboard.

Decomposition:
- Shared package/defines: DATA_W, ADDR_W, REG_NUM tied to the existing `RegBus, `RegAddrBus and `RegNum defines; a zero-register constant.
- One sub-module, wb_fifo: parameterised synchronous FIFO (push/pop/full/empty/count, synchronous active-high rst) holding {rd, data}.
- Scoreboard and arbitration stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all inputs active -> we=0, waddr=0, wdata=0, lsu_ready=1, busy_rs1/busy_rs2/busy_rd=0.
- ALU only: alu_valid=1, rd=5, data=0x1234 -> next cycle we=1, waddr=5, wdata=0x1234. alu_rd=0 -> next cycle we=0.
- Long issue and writeback: issue iss_long rd=7 -> busy_rs1=1 for chk_rs1=7. Later lsu_valid rd=7, data=0xDEADBEEF with no ALU -> next cycle we=1, waddr=7, and busy clears that same cycle.
- Collision: alu_valid and lsu_valid in the same cycle (rd=3 and rd=9) -> ALU write first, rd=9 written the following cycle. Three consecutive collisions with FIFO_DEPTH=2 -> lsu_ready=0 after 2 enqueues; no result is lost; order is preserved.
- Same-cycle set and clear: long result for rd=4 pops while a new long op issues to rd=4 -> write occurs and busy_rs1(4) stays 1.
- Reset mid-operation: FIFO holding 2 entries, scoreboard bits 7 and 9 set, rst=1 for 1 cycle -> no writes afterwards, all busy=0, lsu_ready=1.
